// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared pipeline control state encoding and register constants.
package rv32_pipe_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, HALT} pipe_state_t;
  localparam logic [4:0] X0 = 5'd0;
endpackage

// File: rtl/rv32_perf_counter.sv
// rv32_perf_counter: wrapping event counter with synchronous clear.
module rv32_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge clk)
    if (rst) r_count <= '0;
    else if (inc) r_count <= r_count + 1'b1;
  assign count = r_count;
endmodule

// File: rtl/rv32_hazard_ctrl.sv
// rv32_hazard_ctrl: load-use, redirect, memory-wait and halt sequencing for the 5-stage pipeline.
module rv32_hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int REDIRECT_FLUSH = 2,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_halt,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             pipe_busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);
  localparam int FW = (REDIRECT_FLUSH > 2) ? $clog2(REDIRECT_FLUSH) : 1;
  pipe_state_t r_state, w_state_nx;
  logic [FW-1:0] r_left, w_left_nx;
  logic w_lu, w_stall_inc, w_flush_inc, w_wait_inc;
  assign w_lu = ex_is_load && ex_rd != X0 &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= RUN;
      r_left  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_left  <= w_left_nx;
    end
  always_comb begin
    w_state_nx  = r_state;
    w_left_nx   = r_left;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    pipe_busy   = 1'b0;
    halted      = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    w_wait_inc  = 1'b0;
    if (rst) begin
      w_state_nx = RUN;
      w_left_nx  = '0;
      pc_hold    = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (r_state == HALT) begin
      halted     = 1'b1;
      pc_hold    = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      // A frozen EX keeps any pending redirect visible, so it is handled once the wait ends.
      pipe_busy  = 1'b1;
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      w_wait_inc = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      w_flush_inc = 1'b1;
      w_state_nx  = (REDIRECT_FLUSH > 1) ? FLUSH : RUN;
      w_left_nx   = (REDIRECT_FLUSH > 1) ? FW'(REDIRECT_FLUSH - 2) : '0;
    end else if (r_state == FLUSH) begin
      ifid_flush = 1'b1;
      w_state_nx = (r_left == '0) ? RUN : FLUSH;
      w_left_nx  = (r_left == '0) ? r_left : r_left - 1'b1;
    end else if (ex_halt) begin
      pc_hold    = 1'b1;
      ifid_flush = 1'b1;
      w_state_nx = HALT;
    end else if (w_lu) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_stall  = 1'b1;
      w_stall_inc = 1'b1;
    end
  end
  rv32_perf_counter #(.CNT_W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(w_stall_inc), .count(stall_cnt));
  rv32_perf_counter #(.CNT_W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(w_flush_inc), .count(flush_cnt));
  rv32_perf_counter #(.CNT_W(CNT_W)) u_wait  (.clk(clk), .rst(rst), .inc(w_wait_inc),  .count(wait_cnt));
endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// tb_rv32_hazard_ctrl: directed vectors and sequences for the hazard controller.
module tb_rv32_hazard_ctrl;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       rdr;
    logic       hlt;
    logic       bsy;
  } in_t;
  typedef struct packed {
    in_t        i;
    logic [6:0] e;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, ex_halt, mem_busy;
  logic pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush, pipe_busy, halted;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
  logic pc_hold4, ifid_hold4, ifid_flush4, idex_stall4, idex_flush4, pipe_busy4, halted4;
  logic [3:0] stall_cnt4, flush_cnt4, wait_cnt4;
  logic [6:0] o;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  assign o = {pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush, pipe_busy, halted};
  rv32_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_halt(ex_halt), .mem_busy(mem_busy), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .pipe_busy(pipe_busy), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .wait_cnt(wait_cnt));
  rv32_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_halt(ex_halt), .mem_busy(mem_busy), .pc_hold(pc_hold4), .ifid_hold(ifid_hold4),
    .ifid_flush(ifid_flush4), .idex_stall(idex_stall4), .idex_flush(idex_flush4),
    .pipe_busy(pipe_busy4), .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4),
    .wait_cnt(wait_cnt4));
  function automatic in_t mk(input logic [4:0] rs1, rs2, input logic u1, u2,
                             input logic [4:0] rd, input logic ld, rdr, hlt, bsy);
    mk = '{rs1, rs2, u1, u2, rd, ld, rdr, hlt, bsy};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic apply(input in_t v);
    {id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_redirect, ex_halt, mem_busy} = v;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input in_t v, input logic [6:0] e, input string nm);
    apply(v);
    #2;
    chk(nm, {25'd0, o}, {25'd0, e});
    tick();
  endtask
  task automatic do_rst();
    rst = 1'b1;
    apply('0);
    #2;
    chk("rst_out", {25'd0, o}, 32'h54);
    tick();
    rst = 1'b0;
  endtask
  vec_t tv[13];
  in_t z, lu, r, b, br, h;
  initial begin
    z  = '0;
    lu = mk(5'd5, 5'd1, 1, 0, 5'd5, 1, 0, 0, 0);
    r  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
    b  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
    br = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);
    h  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    tv[0]  = '{z, 7'b0000000};
    tv[1]  = '{lu, 7'b1101000};
    tv[2]  = '{mk(5'd5, 5'd1, 0, 1, 5'd5, 1, 0, 0, 0), 7'b0000000};
    tv[3]  = '{mk(5'd2, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0), 7'b1101000};
    tv[4]  = '{mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0), 7'b0000000};
    tv[5]  = '{mk(5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0), 7'b0000000};
    tv[6]  = '{r, 7'b0010100};
    tv[7]  = '{mk(5'd5, 5'd1, 1, 0, 5'd5, 1, 1, 0, 0), 7'b0010100};
    tv[8]  = '{br, 7'b1100010};
    tv[9]  = '{h, 7'b1010000};
    tv[10] = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1), 7'b1100010};
    tv[11] = '{mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0), 7'b0010100};
    tv[12] = '{mk(5'd5, 5'd1, 1, 0, 5'd5, 1, 0, 0, 1), 7'b1100010};
    rst = 1'b1;
    apply(z);
    #2;
    chk("rst_first", {25'd0, o}, 32'h54);
    tick();
    rst = 1'b0;
    apply(z);
    #2;
    chk("cnt0_stall", stall_cnt, 0);
    chk("cnt0_flush", flush_cnt, 0);
    chk("cnt0_wait", wait_cnt, 0);
    for (int i = 0; i < 13; i++) begin
      do_rst();
      cyc(tv[i].i, tv[i].e, $sformatf("vec%0d", i));
    end
    do_rst();
    cyc(mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0), 7'b0000000, "x0_load");
    chk("x0_stall_cnt", stall_cnt, 0);
    cyc(lu, 7'b1101000, "lu_cycle");
    cyc(z, 7'b0000000, "lu_after");
    chk("lu_stall_cnt", stall_cnt, 1);
    do_rst();
    cyc(r, 7'b0010100, "redir_n");
    cyc(z, 7'b0010000, "redir_n1");
    cyc(z, 7'b0000000, "redir_n2");
    chk("redir_flush_cnt", flush_cnt, 1);
    do_rst();
    for (int i = 0; i < 3; i++) cyc(br, 7'b1100010, $sformatf("busy_redir%0d", i));
    cyc(r, 7'b0010100, "busy_then_redir");
    cyc(z, 7'b0010000, "busy_then_flush");
    cyc(z, 7'b0000000, "busy_then_idle");
    chk("busy_wait_cnt", wait_cnt, 3);
    chk("busy_flush_cnt", flush_cnt, 1);
    do_rst();
    cyc(r, 7'b0010100, "fx_redir");
    cyc(b, 7'b1100010, "fx_busy0");
    cyc(b, 7'b1100010, "fx_busy1");
    cyc(z, 7'b0010000, "fx_exit");
    cyc(z, 7'b0000000, "fx_run");
    do_rst();
    cyc(r, 7'b0010100, "rf_redir");
    do_rst();
    cyc(z, 7'b0000000, "rf_no_residual");
    do_rst();
    cyc(lu, 7'b1101000, "h_lu");
    cyc(b, 7'b1100010, "h_busy");
    cyc(r, 7'b0010100, "h_redir");
    cyc(z, 7'b0010000, "h_flush");
    cyc(h, 7'b1010000, "h_enter");
    for (int i = 0; i < 10; i++) cyc(lu, 7'b1010101, $sformatf("h_hold%0d", i));
    chk("h_stall_cnt", stall_cnt, 1);
    chk("h_flush_cnt", flush_cnt, 1);
    chk("h_wait_cnt", wait_cnt, 1);
    do_rst();
    apply(z);
    #2;
    chk("h_rst_out", {25'd0, o}, 0);
    chk("h_rst_stall", stall_cnt, 0);
    chk("h_rst_flush", flush_cnt, 0);
    chk("h_rst_wait", wait_cnt, 0);
    tick();
    do_rst();
    for (int i = 0; i < 17; i++) begin
      cyc(lu, 7'b1101000, "wrap_lu");
      cyc(z, 7'b0000000, "wrap_idle");
    end
    chk("wrap_stall4", {28'd0, stall_cnt4}, 1);
    chk("wrap_stall32", stall_cnt, 17);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
